alu_serial_ctrl: RTL and testbench
==================================

ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request to begin an operation
- op  in  3  operation code
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  operation result
- c_out  out  1  final carry of ADD/SUB/SLT
- ovf  out  1  signed overflow of ADD/SUB
- zero  out  1  result == 0
- err  out  1  illegal op code seen

Function
REQ-003 SHALL compute the operation bit-serially, LSB first, through one alu1b slice instance, one bit per clock.
REQ-004 SHALL use these op codes and slice drives {a_inv, b_inv, s1s0, initial c_in}:
- 000 AND {0,0,00,0}
- 001 OR {0,0,01,0}
- 010 ADD {0,0,10,0}
- 011 SUB {0,1,10,1}
- 100 NOR {1,1,00,0}
- 101 SLT {0,1,10,1}
REQ-005 SHALL use states IDLE, RUN, DONE.
REQ-006 In IDLE or DONE with start=1, SHALL latch a, b and op, clear the bit index and carry register, load carry with the initial c_in, and enter RUN.
REQ-007 In RUN, SHALL drive the slice with bit i of the latched operands and the carry register, store slice x into result shift register bit i, and store slice c_out into the carry register.
REQ-008 After bit WIDTH-1, SHALL enter DONE; DONE SHALL last exactly one cycle, then return to IDLE unless start=1.
REQ-009 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-010 Latency: start sampled at edge k -> done=1 in the cycle after edge k+WIDTH+1.
REQ-011 start while busy=1 SHALL be ignored; operand/op changes during RUN SHALL have no effect.
REQ-012 result, c_out, ovf, zero and err SHALL update only on entry to DONE and hold until the next DONE or reset.
REQ-013 SLT SHALL produce result = {WIDTH-1 zeros, set}, with set defined in REQ-019; c_out is the final subtraction carry.
REQ-014 ovf SHALL be 0 for AND, OR, NOR and SLT.
REQ-015 Op 110/111 SHALL run the full WIDTH cycles, then give result=0, c_out=0, ovf=0, zero=1 and err=1; err SHALL be 0 for legal ops.

Reset
REQ-016 While rst_n=0, SHALL force state IDLE, busy=0, done=0, result=0, c_out=0, ovf=0, zero=0, err=0, and clear all internal registers.
REQ-017 Reset during RUN SHALL abort the operation with no done pulse.

Configuration
REQ-018 Macro ALU_SERIAL_OVF_EN SHALL enable overflow tracking.
REQ-019 With the macro defined:
- ovf = carry into MSB XOR carry out of MSB, for ADD/SUB
- SLT set = MSB of difference XOR overflow
Without the macro:
- ovf is tied to 0
- SLT set = MSB of difference

Structure
REQ-020 Package alu_serial_pkg SHALL hold the op-code enum, the state enum, and the op -> slice-drive decode constants.
REQ-021 The existing alu1b module SHALL be instantiated once as the only sub-module.

Verification
REQ-022 Benches SHALL use WIDTH=8 and cover:
- AND a=0xF0, b=0x3C -> result=0x30, zero=0, done exactly 9 cycles after start
- ADD a=0xFF, b=0x01 -> result=0x00, c_out=1, zero=1, ovf=0
- SUB a=0x80, b=0x01 -> result=0x7F, ovf=1 with ALU_SERIAL_OVF_EN, ovf=0 without it
- SLT a=0x80, b=0x01 -> result=0x01 with the macro, 0x00 without it; SLT a=0x01, b=0x02 -> result=0x01 in both builds
- start pulsed mid-RUN with new operands -> ignored, first result unchanged; start held during DONE -> back-to-back operation, no IDLE cycle
- rst_n low at RUN bit 4 -> all outputs 0, no done; op=111 afterwards -> err=1, result=0

Source files
------------

// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU controller: op codes, FSM states
// and the op -> one-bit-slice drive decode.
package alu_serial_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_NOR = 3'b100,
    OP_SLT = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Control drive of the one-bit slice: {a_inv, b_inv, sel, initial carry}
  typedef struct packed {
    logic       a_inv;
    logic       b_inv;
    logic [1:0] sel;
    logic       c_in;
  } slice_drv_t;

  localparam slice_drv_t DRV_AND = '{a_inv: 1'b0, b_inv: 1'b0, sel: 2'b00, c_in: 1'b0};
  localparam slice_drv_t DRV_OR  = '{a_inv: 1'b0, b_inv: 1'b0, sel: 2'b01, c_in: 1'b0};
  localparam slice_drv_t DRV_ADD = '{a_inv: 1'b0, b_inv: 1'b0, sel: 2'b10, c_in: 1'b0};
  localparam slice_drv_t DRV_SUB = '{a_inv: 1'b0, b_inv: 1'b1, sel: 2'b10, c_in: 1'b1};
  localparam slice_drv_t DRV_NOR = '{a_inv: 1'b1, b_inv: 1'b1, sel: 2'b00, c_in: 1'b0};
  localparam slice_drv_t DRV_SLT = '{a_inv: 1'b0, b_inv: 1'b1, sel: 2'b10, c_in: 1'b1};

  // Illegal op codes still run the full sequence; the slice is given a
  // harmless AND drive and the outputs are overridden at the end.
  function automatic slice_drv_t decode_op(input logic [2:0] op);
    slice_drv_t drv;
    case (op)
      OP_AND:  drv = DRV_AND;
      OP_OR:   drv = DRV_OR;
      OP_ADD:  drv = DRV_ADD;
      OP_SUB:  drv = DRV_SUB;
      OP_NOR:  drv = DRV_NOR;
      OP_SLT:  drv = DRV_SLT;
      default: drv = DRV_AND;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/alu1b.sv
// One-bit ALU slice: optional operand inversion, AND / OR / full-add select.
module alu1b (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       a_inv_i,
  input  logic       b_inv_i,
  input  logic       c_in_i,
  input  logic [1:0] sel_i,
  output logic       x_o,
  output logic       c_out_o
);

  logic aa_s;
  logic bb_s;

  // Combinational slice: invert operands, then select the bit function
  always_comb begin
    aa_s    = a_i ^ a_inv_i;
    bb_s    = b_i ^ b_inv_i;
    c_out_o = (aa_s & bb_s) | (aa_s & c_in_i) | (bb_s & c_in_i);
    case (sel_i)
      2'b00:   x_o = aa_s & bb_s;
      2'b01:   x_o = aa_s | bb_s;
      2'b10:   x_o = aa_s ^ bb_s ^ c_in_i;
      default: x_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: processes one operand bit per clock, LSB first,
// through a single alu1b slice, then commits the flags in a DONE cycle.
// Optional feature: define ALU_SERIAL_OVF_EN to enable signed-overflow
// tracking (ovf output and overflow-corrected SLT).
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             err
);
  import alu_serial_pkg::*;

  localparam int CNTW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d;
  logic [2:0]       op_q, op_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d, ovf_q, ovf_d, zero_q, zero_d, err_q, err_d;

  slice_drv_t       drv_s;
  slice_drv_t       load_drv_s;
  logic             x_s, co_s;
  logic             load_s, step_s;
  logic             ovf_track_s;
  logic             set_s;

  assign drv_s      = decode_op(op_q);
  assign load_drv_s = decode_op(op);
  // A new request is accepted only when not in RUN; a step happens while
  // bits remain, the extra RUN cycle at cnt==WIDTH commits the outputs.
  assign load_s     = (state_q != ST_RUN) && start;
  assign step_s     = (state_q == ST_RUN) && (cnt_q != CNTW'(WIDTH));

  alu1b u_slice (
    .a_i     (a_q[0]),
    .b_i     (b_q[0]),
    .a_inv_i (drv_s.a_inv),
    .b_inv_i (drv_s.b_inv),
    .c_in_i  (carry_q),
    .sel_i   (drv_s.sel),
    .x_o     (x_s),
    .c_out_o (co_s)
  );

`ifdef ALU_SERIAL_OVF_EN
  logic cmsb_q, cmsb_d;

  // Capture the carry entering the MSB while the MSB is being processed
  always_comb begin
    cmsb_d = cmsb_q;
    if (load_s) begin
      cmsb_d = 1'b0;
    end else if (step_s && (cnt_q == CNTW'(WIDTH - 1))) begin
      cmsb_d = carry_q;
    end else begin
      cmsb_d = cmsb_q;
    end
  end

  // Carry-into-MSB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmsb_q <= 1'b0;
    end else begin
      cmsb_q <= cmsb_d;
    end
  end

  assign ovf_track_s = cmsb_q ^ carry_q;
`else
  assign ovf_track_s = 1'b0;
`endif

  assign set_s = sh_q[WIDTH-1] ^ ovf_track_s;

  // Next-state, datapath step and output commit
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (load_s) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          sh_d    = '0;
          carry_d = load_drv_s.c_in;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (step_s) begin
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          sh_d    = {x_s, sh_q[WIDTH-1:1]};
          carry_d = co_s;
          cnt_d   = cnt_q + CNTW'(1);
        end else begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          case (op_q)
            OP_AND, OP_OR, OP_NOR: begin
              result_d = sh_q;
              c_out_d  = 1'b0;
              ovf_d    = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              result_d = sh_q;
              c_out_d  = carry_q;
              ovf_d    = ovf_track_s;
            end
            OP_SLT: begin
              result_d = {{(WIDTH-1){1'b0}}, set_s};
              c_out_d  = carry_q;
              ovf_d    = 1'b0;
            end
            default: begin
              result_d = '0;
              c_out_d  = 1'b0;
              ovf_d    = 1'b0;
              err_d    = 1'b1;
            end
          endcase
          zero_d = (result_d == '0);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      op_q     <= 3'b000;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl (WIDTH=8); expectations come from an
// independent word-level reference model.
module tb_alu_serial_ctrl;
  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH + 1;
  localparam int BOUND = 40;

  logic             clk = 1'b0;
  logic             rst_n, start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b, result;
  logic             busy, done, c_out, ovf, zero, err;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;
    logic             zero;
    logic             err;
  } res_t;

  res_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .c_out(c_out),
    .ovf(ovf), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    res_t           r;
    logic [WIDTH:0] s;
    logic           set;
    r = '0;
    s = '0;
    case (o)
      3'd0: r.result = x & y;
      3'd1: r.result = x | y;
      3'd4: r.result = ~(x | y);
      3'd2: begin
        s = {1'b0, x} + {1'b0, y};
        r.result = s[WIDTH-1:0];
        r.c_out  = s[WIDTH];
`ifdef ALU_SERIAL_OVF_EN
        r.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
`endif
      end
      3'd3: begin
        s = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
        r.result = s[WIDTH-1:0];
        r.c_out  = s[WIDTH];
`ifdef ALU_SERIAL_OVF_EN
        r.ovf = (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
`endif
      end
      3'd5: begin
        s = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
        r.c_out = s[WIDTH];
`ifdef ALU_SERIAL_OVF_EN
        set = ($signed(x) < $signed(y));
`else
        set = s[WIDTH-1];
`endif
        r.result = {{(WIDTH-1){1'b0}}, set};
      end
      default: r.err = 1'b1;
    endcase
    r.zero = (r.result == '0);
    return r;
  endfunction

  // Drive a one-cycle start request and record its expected outcome
  task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    sb_q.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; n = negedges waited
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    res_t z;
    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (3) @(negedge clk);
    z = {result, c_out, ovf, zero, err};
    checks++;
    if ({busy, done, z} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {busy, done, z});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ops();
    logic [2:0]       t_op[12] = '{3'd0, 3'd2, 3'd3, 3'd5, 3'd5, 3'd1, 3'd4, 3'd2, 3'd3, 3'd4, 3'd2, 3'd6};
    logic [WIDTH-1:0] t_a[12]  = '{8'hF0, 8'hFF, 8'h80, 8'h80, 8'h01, 8'h55, 8'h0F, 8'h7F, 8'h05, 8'h00, 8'h3A, 8'h9C};
    logic [WIDTH-1:0] t_b[12]  = '{8'h3C, 8'h01, 8'h01, 8'h01, 8'h02, 8'hA0, 8'hF0, 8'h01, 8'h05, 8'h00, 8'hC5, 8'h21};
    int   n;
    res_t exp_r, obs;
    for (int i = 0; i < 12; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(n);
      checks++;
      if (n != LAT) begin
        errors++;
        $display("FAIL op%0d_latency: got %0d expected %0d", i, n, LAT);
      end
      obs = {result, c_out, ovf, zero, err};
      exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      checks++;
      if (obs !== exp_r) begin
        errors++;
        $display("FAIL op%0d_result: got %h expected %h", i, obs, exp_r);
      end
    end
  endtask

  task automatic test_ignore_start();
    int   n, extra;
    res_t exp_r, obs;
    issue(3'd0, 8'hF0, 8'h3C);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ign_busy: got %b expected 1", busy);
    end
    start = 1'b1; op = 3'd2; a = 8'h11; b = 8'h22;
    @(negedge clk);
    start = 1'b0; a = 8'hAA; b = 8'h55; op = 3'd1;
    wait_done(n);
    checks++;
    if (n + 4 != LAT) begin
      errors++;
      $display("FAIL ign_latency: got %0d expected %0d", n + 4, LAT);
    end
    obs = {result, c_out, ovf, zero, err};
    exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    checks++;
    if (obs !== exp_r) begin
      errors++;
      $display("FAIL ign_result: got %h expected %h", obs, exp_r);
    end
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ign_extra_done: got %0d expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    res_t exp_r, obs;
    issue(3'd2, 8'hFF, 8'h01);
    wait_done(n);
    obs = {result, c_out, ovf, zero, err};
    exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    checks++;
    if (obs !== exp_r) begin
      errors++;
      $display("FAIL b2b_first: got %h expected %h", obs, exp_r);
    end
    start = 1'b1; op = 3'd3; a = 8'h80; b = 8'h01;
    sb_q.push_back(model(3'd3, 8'h80, 8'h01));
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_no_idle: got busy,done=%b expected 10", {busy, done});
    end
    wait_done(n);
    checks++;
    if (n != LAT) begin
      errors++;
      $display("FAIL b2b_latency: got %0d expected %0d", n, LAT);
    end
    obs = {result, c_out, ovf, zero, err};
    exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    checks++;
    if (obs !== exp_r) begin
      errors++;
      $display("FAIL b2b_second: got %h expected %h", obs, exp_r);
    end
  endtask

  task automatic test_reset_mid_run();
    int   n, seen;
    res_t exp_r, obs;
    issue(3'd2, 8'h12, 8'h34);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    obs = {result, c_out, ovf, zero, err};
    checks++;
    if ({busy, done, obs} !== '0) begin
      errors++;
      $display("FAIL rst_run_outputs: got %h expected 0", {busy, done, obs});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_run_no_done: got %0d expected 0", seen);
    end
    issue(3'd7, 8'hC3, 8'h5A);
    wait_done(n);
    checks++;
    if (n != LAT) begin
      errors++;
      $display("FAIL illegal_latency: got %0d expected %0d", n, LAT);
    end
    obs = {result, c_out, ovf, zero, err};
    exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    checks++;
    if (obs !== exp_r) begin
      errors++;
      $display("FAIL illegal_result: got %h expected %h", obs, exp_r);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
